// File: rtl/ysyx_23060072_multdiv_ctrl_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// Holds funct3 op codes, FSM state encodings, the last-iteration index and a negate helper.
package ysyx_23060072_multdiv_ctrl_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [4:0] MD_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic [31:0] md_neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_23060072_multdiv_dp.sv
// Multiply/divide datapath: 64-bit shift register, one shared 33-bit adder/subtractor,
// and the magnitude/sign-correction negators. Outputs reflect the accumulator after the current step.
module ysyx_23060072_multdiv_dp
  import ysyx_23060072_multdiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        div_mode_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        neg_a_i,
  input  logic        neg_b_i,
  input  logic        neg_res_i,
  input  logic        neg_rem_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [63:0] acc_r;
  logic [31:0] opnd_r;
  logic        div_mode_r;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] add_x_s;
  logic [32:0] add_y_s;
  logic [32:0] sum_s;
  logic [63:0] acc_next_s;
  logic [63:0] acc_neg_s;

  assign mag_a_s = neg_a_i ? md_neg32(operand_a_i) : operand_a_i;
  assign mag_b_s = neg_b_i ? md_neg32(operand_b_i) : operand_b_i;

  // One adder: adds multiplicand to the high half (MUL) or trial-subtracts divisor (DIV).
  always_comb begin
    add_x_s    = 33'd0;
    add_y_s    = 33'd0;
    acc_next_s = acc_r;
    if (div_mode_r) begin
      add_x_s = acc_r[63:31];
      add_y_s = ~{1'b0, opnd_r};
    end else begin
      add_x_s = {1'b0, acc_r[63:32]};
      add_y_s = {1'b0, opnd_r};
    end
    sum_s = add_x_s + add_y_s + {32'd0, div_mode_r};
    if (div_mode_r) begin
      if (sum_s[32]) begin
        acc_next_s = {acc_r[62:0], 1'b0};
      end else begin
        acc_next_s = {sum_s[31:0], acc_r[30:0], 1'b1};
      end
    end else begin
      if (acc_r[0]) begin
        acc_next_s = {sum_s, acc_r[31:1]};
      end else begin
        acc_next_s = {1'b0, acc_r[63:1]};
      end
    end
  end

  assign acc_neg_s = ~acc_next_s + 64'd1;
  assign prod_o    = neg_res_i ? acc_neg_s : acc_next_s;
  assign quot_o    = neg_res_i ? md_neg32(acc_next_s[31:0]) : acc_next_s[31:0];
  assign rem_o     = neg_rem_i ? md_neg32(acc_next_s[63:32]) : acc_next_s[63:32];

  // Accumulator and multiplicand/divisor registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r      <= 64'd0;
      opnd_r     <= 32'd0;
      div_mode_r <= 1'b0;
    end else if (load_i) begin
      div_mode_r <= div_mode_i;
      acc_r      <= {32'd0, (div_mode_i ? mag_a_s : mag_b_s)};
      opnd_r     <= div_mode_i ? mag_b_s : mag_a_s;
    end else if (step_i) begin
      acc_r <= acc_next_s;
    end
  end

endmodule

// File: rtl/ysyx_23060072_multdiv_ctrl.sv
// Iterative RV32M multiply/divide unit for the EX stage: FSM, iteration counter and result register.
// Holds EX through the 32 iterations; the result is presented only while in DONE.
module ysyx_23060072_multdiv_ctrl
  import ysyx_23060072_multdiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            multdiv_en_i,
  input  logic [3:0]      op_i,
  input  logic            stall_other_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] multdiv_result_o,
  output logic            hold_flag_o
);

  md_state_e   state_r, state_next_s;
  logic [4:0]  count_r;
  logic [2:0]  op_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic [31:0] result_r;

  logic [2:0]  op_sel_s;
  logic        unused_op_s;
  logic        a_signed_s, b_signed_s, neg_a_s, neg_b_s;
  logic        is_div_s, div_zero_s, div_ovf_s, fast_s;
  logic        busy_s, start_s, step_s, last_s, hold_s;
  logic [31:0] fast_res_s, final_res_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s;

  assign op_sel_s    = op_i[2:0];
  assign unused_op_s = op_i[3];

  assign a_signed_s = (op_sel_s == MD_MULH) | (op_sel_s == MD_MULHSU) |
                      (op_sel_s == MD_DIV)  | (op_sel_s == MD_REM);
  assign b_signed_s = (op_sel_s == MD_MULH) | (op_sel_s == MD_DIV) | (op_sel_s == MD_REM);
  assign neg_a_s    = a_signed_s & operand_a_i[31];
  assign neg_b_s    = b_signed_s & operand_b_i[31];
  assign is_div_s   = op_sel_s[2];
  assign div_zero_s = is_div_s & (operand_b_i == 32'd0);
  assign div_ovf_s  = ((op_sel_s == MD_DIV) | (op_sel_s == MD_REM)) &
                      (operand_a_i == 32'h8000_0000) & (operand_b_i == 32'hFFFF_FFFF);
  assign fast_s     = div_zero_s | div_ovf_s;

  assign busy_s  = (state_r == ST_MUL) | (state_r == ST_DIV);
  assign start_s = (state_r == ST_IDLE) & multdiv_en_i & ~flush_i;
  assign step_s  = busy_s & ~flush_i;
  assign last_s  = (count_r == MD_LAST_ITER);

  // Fast-path result: op bit 1 distinguishes remainder from quotient.
  always_comb begin
    fast_res_s = 32'd0;
    if (div_zero_s) begin
      if (op_sel_s[1]) begin
        fast_res_s = operand_a_i;
      end else begin
        fast_res_s = 32'hFFFF_FFFF;
      end
    end else if (div_ovf_s) begin
      if (op_sel_s[1]) begin
        fast_res_s = 32'd0;
      end else begin
        fast_res_s = 32'h8000_0000;
      end
    end else begin
      fast_res_s = 32'd0;
    end
  end

  ysyx_23060072_multdiv_dp u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_s),
    .step_i     (step_s),
    .div_mode_i (is_div_s),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .neg_a_i    (neg_a_s),
    .neg_b_i    (neg_b_s),
    .neg_res_i  (sign_a_r ^ sign_b_r),
    .neg_rem_i  (sign_a_r),
    .prod_o     (prod_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s)
  );

  // Result selection on the final iteration.
  always_comb begin
    final_res_s = 32'd0;
    case (op_r)
      MD_MUL:                        final_res_s = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  final_res_s = prod_s[63:32];
      MD_DIV, MD_DIVU:               final_res_s = quot_s;
      MD_REM, MD_REMU:               final_res_s = rem_s;
      default:                       final_res_s = 32'd0;
    endcase
  end

  // Next-state and hold request; flush overrides everything and never looks at stall_other_i.
  always_comb begin
    state_next_s = state_r;
    hold_s       = 1'b0;
    if (flush_i) begin
      state_next_s = ST_IDLE;
      hold_s       = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (multdiv_en_i) begin
            hold_s = 1'b1;
            if (fast_s) begin
              state_next_s = ST_DONE;
            end else if (is_div_s) begin
              state_next_s = ST_DIV;
            end else begin
              state_next_s = ST_MUL;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          hold_s = 1'b1;
          if (last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_DONE: begin
          if (stall_other_i) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  assign hold_flag_o      = hold_s;
  assign multdiv_result_o = result_r;

  // State, counter, latched op/signs and the result register (zero outside DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      count_r  <= 5'd0;
      op_r     <= MD_MUL;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      result_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        op_r     <= op_sel_s;
        sign_a_r <= neg_a_s;
        sign_b_r <= neg_b_s;
      end
      if (step_s && !last_s) begin
        count_r <= count_r + 5'd1;
      end else begin
        count_r <= 5'd0;
      end
      if (state_next_s == ST_DONE) begin
        if (start_s) begin
          result_r <= fast_res_s;
        end else if (busy_s) begin
          result_r <= final_res_s;
        end else begin
          result_r <= result_r;
        end
      end else begin
        result_r <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_multdiv_ctrl.sv
// Self-checking bench for ysyx_23060072_multdiv_ctrl: expected results are queued at issue
// and compared when the unit drops its hold and presents the result.
module tb_ysyx_23060072_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        multdiv_en = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        stall_other = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] multdiv_result;
  logic        hold_flag;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] ra, rb, rexp;
  logic [63:0] p64;
  logic [3:0]  rop;
  int          rhold;

  always #5 clk = ~clk;

  ysyx_23060072_multdiv_ctrl #(.XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .operand_a_i     (operand_a),
    .operand_b_i     (operand_b),
    .multdiv_en_i    (multdiv_en),
    .op_i            (op),
    .stall_other_i   (stall_other),
    .flush_i         (flush),
    .multdiv_result_o(multdiv_result),
    .hold_flag_o     (hold_flag)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one op, count hold cycles, compare the scoreboard head, optionally stall in DONE.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_hold,
                        input int stall_cyc);
    int n;
    logic [31:0] want;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    op = o; operand_a = a; operand_b = b; multdiv_en = 1'b1;
    stall_other = (stall_cyc > 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hold_flag) n++;
      else break;
    end
    check_val({tag, "_hold_cycles"}, n, exp_hold);
    want = exp_q.pop_front();
    check_val({tag, "_result"}, multdiv_result, want);
    for (int i = 0; i < stall_cyc; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val({tag, "_stall_result"}, multdiv_result, want);
      check_val({tag, "_stall_hold"}, {31'd0, hold_flag}, 32'd0);
    end
    stall_other = 1'b0;
    @(posedge clk); #1;
    multdiv_en = 1'b0;
    @(negedge clk);
    check_val({tag, "_idle_result"}, multdiv_result, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_result", multdiv_result, 32'd0);
    check_val("reset_hold", {31'd0, hold_flag}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("mul",      4'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh",     4'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhu",    4'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33, 0);
    run_op("mulhsu_m1",4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhu_m1", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("div",      4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem",      4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu",     4'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
    run_op("div_rsvd", 4'd12, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 0);
    run_op("div_by0",  4'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", 4'd7, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("rem_by0",  4'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    run_op("div_ovf",  4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",  4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("mul_stall",4'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 3);

    // Flush on iteration 10 (cycle T+11).
    @(posedge clk); #1;
    op = 4'd0; operand_a = 32'd7; operand_b = 32'd9; multdiv_en = 1'b1;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_val("flush_hold", {31'd0, hold_flag}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; multdiv_en = 1'b0;
    @(negedge clk);
    check_val("flush_idle_hold", {31'd0, hold_flag}, 32'd0);
    check_val("flush_idle_result", multdiv_result, 32'd0);
    run_op("divu_after_flush", 4'd5, 32'd100, 32'd7, 32'd14, 33, 0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    op = 4'd0; operand_a = 32'd7; operand_b = 32'hFFFF_FFFD; multdiv_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; multdiv_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("midreset_result", multdiv_result, 32'd0);
    check_val("midreset_hold", {31'd0, hold_flag}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("remu_after_reset", 4'd7, 32'd100, 32'd7, 32'd2, 33, 0);

    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k == 7) ? 32'd0 : $urandom;
      p64 = {32'd0, ra} * {32'd0, rb};
      rhold = 33;
      case (k % 4)
        0: begin rop = 4'd0; rexp = p64[31:0]; end
        1: begin rop = 4'd3; rexp = p64[63:32]; end
        2: begin rop = 4'd5; rexp = (rb == 32'd0) ? 32'hFFFF_FFFF : ra / rb; end
        default: begin rop = 4'd7; rexp = (rb == 32'd0) ? ra : ra % rb; end
      endcase
      if (rop[2] && rb == 32'd0) rhold = 1;
      run_op("random", rop, ra, rb, rexp, rhold, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060072_multdiv_ctrl.md
# ysyx_23060072_multdiv_ctrl

Iterative RV32M multiply/divide unit with its own sequencing FSM. It sits beside the ALU in the EX stage and stalls the pipeline through the controller while it runs. It returns a single 32-bit result that the EX stage muxes into `wb_data_ex` when `multdiv_en_i` is set. One shared 64-bit shift register and one 33-bit adder serve all eight M-extension operations.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `operand_a_i`  in  32  rs1 value; held stable by the pipeline while `hold_flag_o`=1.
- `operand_b_i`  in  32  rs2 value; held stable by the pipeline while `hold_flag_o`=1.
- `multdiv_en_i`  in  1  the EX instruction is an M-extension op.
- `op_i`  in  4  bits [2:0] carry funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. Bit 3 is reserved and ignored.
- `stall_other_i`  in  1  the EX→LSU register is held by some source other than this unit.
- `flush_i`  in  1  the EX instruction is being killed (jump/clint redirect).
- `multdiv_result_o`  out  32  result; valid only in state DONE, 0 otherwise.
- `hold_flag_o`  out  1  request that the controller hold EX (maps to `multdiv_hold_flag_o`).

## Operation
- FSM states:
  - IDLE
  - MUL: 32 iterations, shift-add on magnitudes.
  - DIV: 32 iterations, restoring divide on magnitudes.
  - DONE.
- IDLE with `multdiv_en_i` & !`flush_i` (start cycle):
  - Latch |a| and |b| per signedness: MULH and DIV/REM treat both operands as signed; MULHSU treats only a as signed; the rest are unsigned.
  - Latch op, sign flags and count=0.
  - Go to MUL or DIV.
- Div-by-zero fast path (b==0): go directly to DONE with quotient 0xFFFF_FFFF and remainder = a (unmodified).
- Signed overflow fast path (DIV/REM, a=0x8000_0000, b=0xFFFF_FFFF): go directly to DONE with quotient 0x8000_0000 and remainder 0.
- MUL iteration: if the multiplier LSB is 1, add the multiplicand into the upper 33 bits, then shift right by 1.
- DIV iteration: shift {rem,quot} left by 1, trial-subtract the divisor, and set the quotient bit when the result is ≥0.
- On the count==31 iteration, write the sign-corrected result into the result register and go to DONE:
  - Product: negate the 64-bit value if the operand signs differ.
  - Quotient: sign = sa^sb.
  - Remainder: sign = sa.
- Result selection: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE:
  - If !`stall_other_i`: go to IDLE (EX latches the result this edge).
  - Else stay in DONE and keep the result stable.
  - `multdiv_en_i` still being high in DONE never restarts the unit.
- `flush_i` in any state: go to IDLE next cycle and force `hold_flag_o`=0 combinationally that cycle.
- `hold_flag_o` = !`flush_i` & ((IDLE & `multdiv_en_i`) | MUL | DIV).

## Timing
- Reset values:
  - state: IDLE.
  - count: 0.
  - result register: 0.
  - `hold_flag_o`: 0.
  - `multdiv_result_o`: 0.
- Normal op, start cycle T:
  - `hold_flag_o`=1 in T..T+32 (33 cycles).
  - DONE at T+33, with the result valid and hold=0.
- Fast path: hold=1 in T only; DONE at T+1.
- Back-to-back M ops: the second starts in the cycle after DONE→IDLE (zero bubble beyond that IDLE cycle).
- Reset during MUL/DIV/DONE: IDLE next edge; any partial result is discarded.
- `hold_flag_o` must not depend on `stall_other_i`, so there is no combinational loop through the controller.

## Structure
- Add to `ysyx_23060072_define.v`:
  - funct3 op codes (`MD_MUL`..`MD_REMU`).
  - FSM state encodings (2-bit).
  - iteration count constant 31.
- One sub-module, `ysyx_23060072_multdiv_dp`: the 64-bit shift register, the 33-bit adder/subtractor and the sign-correction negators. The FSM and counter stay in the top.

## Test plan
- MUL 7×(−3): hold for 33 cycles, then result 0xFFFF_FFEB. MULH with the same operands returns 0xFFFF_FFFF; MULHU returns 0x0000_0006.
- MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF. MULHU with the same operands → 0xFFFF_FFFE.
- DIV −7/2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIVU 0xFFFF_FFF9/2 → 0x7FFF_FFFC.
- DIV 5/0 → 0xFFFF_FFFF and REMU 5/0 → 5, each with one hold cycle. DIV 0x8000_0000/−1 → 0x8000_0000; REM → 0.
- `stall_other_i`=1 for 3 cycles in DONE: the result stays stable, no restart, hold stays 0; IDLE after the stall drops.
- `flush_i` at iteration 10 → hold low that cycle and IDLE next cycle. A new DIVU 100/7 issued afterward returns 14. `rst_n`=0 mid-MUL → all outputs 0 next edge.
